// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags, captures CDB results, retires in program order.
// Latency: CDB write at edge N shows on the commit port during the following cycle; queries are combinational.
// Backpressure: full refuses allocation; rdy low freezes all state; a flush blocks allocation for its cycle.
module reorder_buffer #(
  parameter int DEPTH     = 16,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 alloc_valid,
  input  logic [4:0]           alloc_rd,
  input  logic                 alloc_is_branch,
  output logic [TAG_WIDTH-1:0] alloc_tag,
  output logic                 full,
  input  logic                 cdb_valid,
  input  logic [TAG_WIDTH-1:0] cdb_tag,
  input  logic [31:0]          cdb_value,
  input  logic                 cdb_mispredict,
  input  logic [31:0]          cdb_target_pc,
  input  logic [TAG_WIDTH-1:0] query_tag1,
  input  logic [TAG_WIDTH-1:0] query_tag2,
  output logic                 query_ready1,
  output logic                 query_ready2,
  output logic [31:0]          query_value1,
  output logic [31:0]          query_value2,
  output logic [4:0]           commit_reg,
  output logic [TAG_WIDTH-1:0] commit_rob,
  output logic [31:0]          commit_value,
  output logic                 flush,
  output logic [31:0]          flush_pc
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [IDX_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic [DEPTH-1:0] busy, ready;
  logic [4:0]       rd         [DEPTH];
  logic             is_branch  [DEPTH];
  logic [31:0]      value      [DEPTH];
  logic             mispredict [DEPTH];
  logic [31:0]      target_pc  [DEPTH];

  logic             commit_fire;
  logic             do_alloc;
  logic             wb_hit;
  logic [IDX_W-1:0] wb_idx;

  // Tags are index + 1 so that tag 0 can mean "value already in the register file".
  assign alloc_tag   = TAG_WIDTH'(tail) + TAG_WIDTH'(1);
  assign full        = (count == CNT_W'(DEPTH));
  assign commit_fire = busy[head] && ready[head];
  assign flush       = commit_fire && is_branch[head] && mispredict[head];
  // Gated so flush_pc reads 0 out of reset, when target_pc storage is still undefined.
  assign flush_pc    = flush ? target_pc[head] : 32'd0;
  assign do_alloc    = alloc_valid && !full && !flush;
  assign wb_idx      = IDX_W'(cdb_tag - TAG_WIDTH'(1));
  // Tags above DEPTH do not name any entry and are ignored.
  assign wb_hit      = cdb_valid && (cdb_tag != '0) && (cdb_tag <= TAG_WIDTH'(DEPTH)) && busy[wb_idx];

  assign commit_reg   = commit_fire ? rd[head] : 5'd0;
  assign commit_rob   = commit_fire ? (TAG_WIDTH'(head) + TAG_WIDTH'(1)) : '0;
  assign commit_value = commit_fire ? value[head] : 32'd0;

  // Operand lookup: stored result first, then same-cycle CDB bypass.
  function automatic logic [32:0] lookup(input logic [TAG_WIDTH-1:0] tag);
    logic [IDX_W-1:0] idx;
    idx    = IDX_W'(tag - TAG_WIDTH'(1));
    lookup = 33'd0;
    if (tag == '0) begin
      lookup = {1'b1, 32'd0};
    end else if (tag <= TAG_WIDTH'(DEPTH)) begin
      if (ready[idx]) begin
        lookup = {1'b1, value[idx]};
      end else if (cdb_valid && (cdb_tag == tag)) begin
        lookup = {1'b1, cdb_value};
      end
    end
  endfunction

  // Two independent decoder operand ports.
  always_comb begin
    {query_ready1, query_value1} = lookup(query_tag1);
    {query_ready2, query_value2} = lookup(query_tag2);
  end

  // Control state: pointers, occupancy and per-entry busy/ready flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= '0;
      ready <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (flush) begin
        // Everything younger than the mispredicted branch is discarded.
        busy  <= '0;
        ready <= '0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (wb_hit) ready[wb_idx] <= 1'b1;
        // Clearing after the writeback so a stray write to the retiring entry cannot revive it.
        if (commit_fire) begin
          busy[head]  <= 1'b0;
          ready[head] <= 1'b0;
          head        <= head + IDX_W'(1);
        end
        // Tail entry is never busy unless full, so this cannot clash with the writeback or commit.
        if (do_alloc) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= 1'b0;
          tail        <= tail + IDX_W'(1);
        end
        case ({do_alloc, commit_fire})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Entry payload; only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk) begin
    if (!rst && rdy && !flush) begin
      if (do_alloc) begin
        rd[tail]        <= alloc_rd;
        is_branch[tail] <= alloc_is_branch;
      end
      if (wb_hit) begin
        value[wb_idx]      <= cdb_value;
        mispredict[wb_idx] <= cdb_mispredict;
        target_pc[wb_idx]  <= cdb_target_pc;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: table of per-cycle vectors plus hand-written
// sequences for fill/wrap and rdy stall with a mid-stream reset.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        alloc_valid, alloc_is_branch;
  logic [4:0]  alloc_rd;
  logic [4:0]  alloc_tag;
  logic        full;
  logic        cdb_valid, cdb_mispredict;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_value, cdb_target_pc;
  logic [4:0]  query_tag1, query_tag2;
  logic        query_ready1, query_ready2;
  logic [31:0] query_value1, query_value2;
  logic [4:0]  commit_reg, commit_rob;
  logic [31:0] commit_value;
  logic        flush;
  logic [31:0] flush_pc;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reorder_buffer #(.DEPTH(16), .TAG_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_is_branch(alloc_is_branch),
    .alloc_tag(alloc_tag), .full(full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_mispredict(cdb_mispredict), .cdb_target_pc(cdb_target_pc),
    .query_tag1(query_tag1), .query_tag2(query_tag2),
    .query_ready1(query_ready1), .query_ready2(query_ready2),
    .query_value1(query_value1), .query_value2(query_value2),
    .commit_reg(commit_reg), .commit_rob(commit_rob), .commit_value(commit_value),
    .flush(flush), .flush_pc(flush_pc)
  );

  typedef struct {
    logic rst, rdy, av; logic [4:0] ard; logic abr;
    logic cv; logic [4:0] ct; logic [31:0] cval; logic cmp; logic [31:0] ctgt;
    logic [4:0] q1, q2;
    logic [4:0] e_tag; logic e_full; logic [4:0] e_creg, e_crob; logic [31:0] e_cval;
    logic e_fl; logic [31:0] e_fpc; logic e_qr1; logic [31:0] e_qv1; logic e_qr2; logic [31:0] e_qv2;
  } vec_t;

  function automatic vec_t v(
    input logic r, input logic rd_en, input logic av, input logic [4:0] ard, input logic abr,
    input logic cv, input logic [4:0] ct, input logic [31:0] cval, input logic cmp, input logic [31:0] ctgt,
    input logic [4:0] q1, input logic [4:0] q2,
    input logic [4:0] e_tag, input logic e_full, input logic [4:0] e_creg, input logic [4:0] e_crob,
    input logic [31:0] e_cval, input logic e_fl, input logic [31:0] e_fpc,
    input logic e_qr1, input logic [31:0] e_qv1, input logic e_qr2, input logic [31:0] e_qv2);
    vec_t x;
    x.rst = r; x.rdy = rd_en; x.av = av; x.ard = ard; x.abr = abr;
    x.cv = cv; x.ct = ct; x.cval = cval; x.cmp = cmp; x.ctgt = ctgt; x.q1 = q1; x.q2 = q2;
    x.e_tag = e_tag; x.e_full = e_full; x.e_creg = e_creg; x.e_crob = e_crob; x.e_cval = e_cval;
    x.e_fl = e_fl; x.e_fpc = e_fpc; x.e_qr1 = e_qr1; x.e_qv1 = e_qv1; x.e_qr2 = e_qr2; x.e_qv2 = e_qv2;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    rst = 1'b0; rdy = 1'b1; alloc_valid = 1'b0; alloc_rd = 5'd0; alloc_is_branch = 1'b0;
    cdb_valid = 1'b0; cdb_tag = 5'd0; cdb_value = 32'd0; cdb_mispredict = 1'b0; cdb_target_pc = 32'd0;
    query_tag1 = 5'd0; query_tag2 = 5'd0;
  endtask

  // Advance past the next active edge; inputs are then driven clear of it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_commit(input string tag, input logic [4:0] reg_e, input logic [4:0] rob_e,
                            input logic [31:0] val_e);
    chk({tag, "_commit_reg"}, commit_reg, reg_e);
    chk({tag, "_commit_rob"}, commit_rob, rob_e);
    chk({tag, "_commit_value"}, commit_value, val_e);
  endtask

  vec_t tbl[$];

  initial begin
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    //      rst rdy av ard abr cv ct cval       mp tgt     q1 q2 | tag full creg crob cval     fl fpc     qr1 qv1      qr2 qv2
    tbl.push_back(v(0,1,0,0,0, 0,0,0,0,0, 0,0, 1,0,0,0,0,0,0, 1,0,1,0));                     // reset state
    tbl.push_back(v(0,1,1,3,0, 0,0,0,0,0, 0,0, 1,0,0,0,0,0,0, 1,0,1,0));                     // alloc rd3 -> tag1
    tbl.push_back(v(0,1,0,0,0, 1,1,32'hDEAD,0,0, 1,0, 2,0,0,0,0,0,0, 1,32'hDEAD,1,0));       // CDB bypass
    tbl.push_back(v(0,1,0,0,0, 0,0,0,0,0, 1,0, 2,0,3,1,32'hDEAD,0,0, 1,32'hDEAD,1,0));       // commit tag1
    tbl.push_back(v(0,1,0,0,0, 0,0,0,0,0, 1,0, 2,0,0,0,0,0,0, 0,0,1,0));                     // retired, gone
    tbl.push_back(v(1,1,0,0,0, 0,0,0,0,0, 0,0, 2,0,0,0,0,0,0, 1,0,1,0));                     // reset
    tbl.push_back(v(0,1,1,5,0, 0,0,0,0,0, 0,0, 1,0,0,0,0,0,0, 1,0,1,0));                     // alloc tag1
    tbl.push_back(v(0,1,1,6,0, 0,0,0,0,0, 0,0, 2,0,0,0,0,0,0, 1,0,1,0));                     // alloc tag2
    tbl.push_back(v(0,1,0,0,0, 1,2,32'h22,0,0, 1,2, 3,0,0,0,0,0,0, 0,0,1,32'h22));           // wb tag2 first
    tbl.push_back(v(0,1,0,0,0, 0,0,0,0,0, 0,2, 3,0,0,0,0,0,0, 1,0,1,32'h22));                // no commit yet
    tbl.push_back(v(0,1,0,0,0, 1,1,32'h11,0,0, 1,0, 3,0,0,0,0,0,0, 1,32'h11,1,0));           // wb tag1
    tbl.push_back(v(0,1,0,0,0, 0,0,0,0,0, 0,0, 3,0,5,1,32'h11,0,0, 1,0,1,0));                // commit 1
    tbl.push_back(v(0,1,0,0,0, 0,0,0,0,0, 0,0, 3,0,6,2,32'h22,0,0, 1,0,1,0));                // commit 2
    tbl.push_back(v(0,1,0,0,0, 0,0,0,0,0, 0,0, 3,0,0,0,0,0,0, 1,0,1,0));                     // drained
    tbl.push_back(v(1,1,0,0,0, 0,0,0,0,0, 0,0, 3,0,0,0,0,0,0, 1,0,1,0));                     // reset
    tbl.push_back(v(0,1,1,1,1, 0,0,0,0,0, 0,0, 1,0,0,0,0,0,0, 1,0,1,0));                     // branch tag1
    tbl.push_back(v(0,1,1,2,0, 0,0,0,0,0, 0,0, 2,0,0,0,0,0,0, 1,0,1,0));                     // tag2
    tbl.push_back(v(0,1,1,4,0, 0,0,0,0,0, 0,0, 3,0,0,0,0,0,0, 1,0,1,0));                     // tag3
    tbl.push_back(v(0,1,0,0,0, 1,2,32'h2,0,0, 0,0, 4,0,0,0,0,0,0, 1,0,1,0));                 // wb tag2
    tbl.push_back(v(0,1,0,0,0, 1,3,32'h3,0,0, 0,0, 4,0,0,0,0,0,0, 1,0,1,0));                 // wb tag3
    tbl.push_back(v(0,1,0,0,0, 1,1,32'h1,1,32'h100, 0,0, 4,0,0,0,0,0,0, 1,0,1,0));           // wb mispredict
    tbl.push_back(v(0,1,1,7,0, 0,0,0,0,0, 2,0, 4,0,1,1,32'h1,1,32'h100, 1,32'h2,1,0));       // commit+flush
    tbl.push_back(v(0,1,0,0,0, 0,0,0,0,0, 2,0, 1,0,0,0,0,0,0, 0,0,1,0));                     // tag2 squashed
    tbl.push_back(v(0,1,0,0,0, 0,0,0,0,0, 3,0, 1,0,0,0,0,0,0, 0,0,1,0));                     // tag3 squashed
    tbl.push_back(v(0,1,1,8,1, 0,0,0,0,0, 0,0, 1,0,0,0,0,0,0, 1,0,1,0));                     // branch tag1
    tbl.push_back(v(0,1,0,0,0, 1,1,32'h8,1,32'h200, 0,0, 2,0,0,0,0,0,0, 1,0,1,0));           // wb mispredict
    tbl.push_back(v(1,1,1,9,0, 0,0,0,0,0, 0,0, 2,0,8,1,32'h8,1,32'h200, 1,0,1,0));           // rst during flush
    tbl.push_back(v(0,1,0,0,0, 0,0,0,0,0, 0,0, 1,0,0,0,0,0,0, 1,0,1,0));                     // clean reset state

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; rdy = tbl[i].rdy;
      alloc_valid = tbl[i].av; alloc_rd = tbl[i].ard; alloc_is_branch = tbl[i].abr;
      cdb_valid = tbl[i].cv; cdb_tag = tbl[i].ct; cdb_value = tbl[i].cval;
      cdb_mispredict = tbl[i].cmp; cdb_target_pc = tbl[i].ctgt;
      query_tag1 = tbl[i].q1; query_tag2 = tbl[i].q2;
      @(negedge clk);
      chk($sformatf("v%0d_alloc_tag", i), alloc_tag, tbl[i].e_tag);
      chk($sformatf("v%0d_full", i), full, tbl[i].e_full);
      chk_commit($sformatf("v%0d", i), tbl[i].e_creg, tbl[i].e_crob, tbl[i].e_cval);
      chk($sformatf("v%0d_flush", i), flush, tbl[i].e_fl);
      chk($sformatf("v%0d_flush_pc", i), flush_pc, tbl[i].e_fpc);
      chk($sformatf("v%0d_qr1", i), query_ready1, tbl[i].e_qr1);
      chk($sformatf("v%0d_qv1", i), query_value1, tbl[i].e_qv1);
      chk($sformatf("v%0d_qr2", i), query_ready2, tbl[i].e_qr2);
      chk($sformatf("v%0d_qv2", i), query_value2, tbl[i].e_qv2);
      tick();
    end

    // Fill all 16 entries, refuse while full (even with a commit), then wrap to tag 1.
    idle(); rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      alloc_valid = 1'b1; alloc_rd = 5'(i + 1);
      @(negedge clk);
      chk($sformatf("fill%0d_tag", i), alloc_tag, 32'(i + 1));
      chk($sformatf("fill%0d_full", i), full, 0);
      tick();
    end
    alloc_rd = 5'd20;
    @(negedge clk);
    chk("full_set", full, 1);
    chk("full_tag_wrapped", alloc_tag, 1);
    tick();
    cdb_valid = 1'b1; cdb_tag = 5'd1; cdb_value = 32'hA1;
    @(negedge clk);
    chk("full_still", full, 1);
    tick();
    cdb_valid = 1'b0;
    @(negedge clk);
    chk("full_during_commit", full, 1);
    chk_commit("full", 5'd1, 5'd1, 32'hA1);
    tick();
    @(negedge clk);
    chk("after_commit_full", full, 0);
    chk("after_commit_tag", alloc_tag, 1);
    tick();
    alloc_valid = 1'b0;
    @(negedge clk);
    chk("wrap_alloc_full", full, 1);
    chk("wrap_alloc_tag", alloc_tag, 2);
    tick();

    // rdy low freezes state; combinational outputs stay live; rst mid-stream.
    idle(); rst = 1'b1; tick(); rst = 1'b0;
    alloc_valid = 1'b1; alloc_rd = 5'd9;
    tick();
    rdy = 1'b0; alloc_rd = 5'd10; cdb_valid = 1'b1; cdb_tag = 5'd1; cdb_value = 32'h55; query_tag1 = 5'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_tag", i), alloc_tag, 2);
      chk($sformatf("hold%0d_commit_reg", i), commit_reg, 0);
      chk($sformatf("hold%0d_qr1", i), query_ready1, 1);
      chk($sformatf("hold%0d_qv1", i), query_value1, 32'h55);
      tick();
    end
    rdy = 1'b1;
    @(negedge clk);
    chk("release_tag", alloc_tag, 2);
    tick();
    idle();
    @(negedge clk);
    chk("release_alloc_tag", alloc_tag, 3);
    chk_commit("release", 5'd9, 5'd1, 32'h55);
    tick();
    cdb_valid = 1'b1; cdb_tag = 5'd2; cdb_value = 32'h66;
    tick();
    idle();
    @(negedge clk);
    chk_commit("pre_rst", 5'd10, 5'd2, 32'h66);
    rst = 1'b1;
    tick();
    rst = 1'b0; query_tag1 = 5'd2;
    @(negedge clk);
    chk("rst_alloc_tag", alloc_tag, 1);
    chk("rst_full", full, 0);
    chk_commit("rst", 5'd0, 5'd0, 32'd0);
    chk("rst_flush", flush, 0);
    chk("rst_flush_pc", flush_pc, 0);
    chk("rst_qr1", query_ready1, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular reorder buffer that allocates ROB tags to decoded instructions, captures results from the common data bus (CDB), and retires entries strictly in program order. It drives the commit port of the rename register file: destination register, ROB tag and value. It also serves operand look-ups by ROB tag to the decoder, and on a mispredicted branch it raises a one-cycle flush with the redirect PC.

## Interface
- DEPTH, 16, number of entries (power of two)
- TAG_WIDTH, 5, ROB tag width; tag = entry index + 1, tag 0 means "no ROB entry"
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; when low, no state changes
- alloc_valid  in  1  decoder requests an entry this cycle
- alloc_rd  in  5  destination register (0 = none)
- alloc_is_branch  in  1  entry may mispredict
- alloc_tag  out  TAG_WIDTH  tag granted to the requester (tail index + 1), combinational
- full  out  1  count == DEPTH, combinational
- cdb_valid  in  1  result broadcast valid
- cdb_tag  in  TAG_WIDTH  producing ROB tag
- cdb_value  in  32  result value
- cdb_mispredict  in  1  branch outcome differs from prediction
- cdb_target_pc  in  32  correct next PC for a mispredicted branch
- query_tag1, query_tag2  in  TAG_WIDTH  decoder operand tags
- query_ready1, query_ready2  out  1  value available, combinational
- query_value1, query_value2  out  32  value, combinational
- commit_reg  out  5  register written this edge; 0 = no commit
- commit_rob  out  TAG_WIDTH  tag of the committing entry
- commit_value  out  32  committed value
- flush  out  1  mispredict flush pulse
- flush_pc  out  32  redirect PC, valid while flush = 1

## Operation
- State: head, tail (log2 DEPTH bits, wrapping), count (0..DEPTH), and per entry: busy, ready, rd, is_branch, value, mispredict, target_pc.
- Allocate: at the edge with rdy && alloc_valid && !full && !flush, write entry[tail] with busy = 1, ready = 0 and the rd/is_branch fields. Then tail += 1 mod DEPTH.
- Writeback: at the edge with rdy && cdb_valid && cdb_tag != 0 && entry[cdb_tag-1].busy, set ready = 1 and store value, mispredict and target_pc. Writebacks to non-busy entries are ignored.
- Commit: fires when entry[head].busy && entry[head].ready. The commit outputs are combinational from head:
  - commit_reg = rd
  - commit_rob = head + 1
  - commit_value = value
- When commit does not fire, all three commit outputs are 0. At the edge with rdy, a committing entry is cleared and head += 1.
- Flush: flush = commit firing && head.is_branch && head.mispredict, and flush_pc = head.target_pc. The branch's own rd is still committed in the same cycle. At that edge, all busy bits clear, head = tail = 0, count = 0, and allocation is blocked.
- Count: +1 on allocate, -1 on commit, unchanged when both happen; set to 0 on flush.
- Query: tag 0 → ready = 1, value = 0. Otherwise the lookup proceeds in priority order:
  - entry ready → stored value
  - cdb_valid && cdb_tag matches → cdb_value (bypass)
  - otherwise ready = 0, value = 0
- Reset: every busy/ready bit, head, tail and count go to 0. In reset state full = 0, alloc_tag = 1, commit_reg = 0, commit_rob = 0, commit_value = 0, flush = 0 and flush_pc = 0.

## Timing
- Allocation latency: the tag shown on alloc_tag is owned from the next edge onward.
- CDB write at edge N → commit outputs are asserted in the following cycle → the register file updates at edge N+1.
- Throughput: one allocate, one writeback and one commit per cycle.
- When full, allocate is refused even if a commit fires in the same cycle, because full is computed from count.
- Allocate and commit on the same entry index (count == 0) cannot collide, since an entry is never ready in its allocation cycle.
- rdy low: every register holds. Combinational outputs stay live but the register file ignores them.
- Tail wraps from DEPTH-1 to 0, giving tag sequence 15, 16, 1.
- rst has priority over every other input, including an in-flight flush.

## Test plan
- Reset, then allocate rd = 3 → alloc_tag = 1. CDB tag 1 value 0xDEAD → the next cycle shows commit_reg = 3, commit_rob = 1, commit_value = 0xDEAD; count returns to 0.
- Allocate tags 1 and 2, write back tag 2 first → no commit until tag 1 is written. Then the two commits appear in consecutive cycles, in order 1 then 2.
- Allocate 16 entries → full = 1 and the 17th request is refused. Commit one entry → full = 0, and the next allocation gets tag 1 after wrap.
- Branch at tag 1 mispredicted with target 0x100, younger tags 2 and 3 already ready → commit of tag 1 with flush = 1 and flush_pc = 0x100. Tags 2 and 3 are never committed, and the next allocation gets tag 1.
- Query tag 2 while CDB broadcasts tag 2 value 7 → query_ready = 1, query_value = 7 in the same cycle. Query tag 0 → ready = 1, value = 0.
- Hold rdy low for 3 cycles with a pending CDB write and an allocation → no state change. Raise rdy and verify the events take effect; assert rst mid-stream and verify all outputs return to their reset values.
